exp_sequencer: RTL and testbench

EXP_SEQUENCER -- requirements
Module: exp_sequencer

---
 rtl/exp_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_exp_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/exp_sequencer.sv
// Left-to-right square-and-multiply schedule generator for a Montgomery multiplier.
// Optional leading-zero skip (SCAN state) enabled by defining EXP_SEQ_SKIP_LZ_EN.
module exp_sequencer #(
    parameter int EXP_W = 512
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              start,
    input  logic [EXP_W-1:0]                  exponent,
    output logic                              mul_start,
    output logic [1:0]                        mul_sel,
    input  logic                              mul_done,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(2*EXP_W+3)-1:0]      op_count
);

    // state  | meaning
    // IDLE   | waiting for start
    // PRE    | issue x*R2 (operand conversion)
    // PRE_W  | wait for conversion result
    // SCAN   | skip leading zero exponent bits, one per cycle
    // SQ     | issue A*A
    // SQ_W   | wait for square
    // MUL    | issue A*xt for a set bit
    // MUL_W  | wait for multiply
    // POST   | issue A*1 (conversion out of Montgomery form)
    // POST_W | wait for final result
    // FIN    | pulse done

    localparam int CNT_W = $clog2(2*EXP_W+3);
    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W-1);

    localparam logic [1:0] SEL_SQ   = 2'b00;
    localparam logic [1:0] SEL_MUL  = 2'b01;
    localparam logic [1:0] SEL_POST = 2'b10;
    localparam logic [1:0] SEL_PRE  = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        PRE,
        PRE_W,
        SCAN,
        SQ,
        SQ_W,
        MUL,
        MUL_W,
        POST,
        POST_W,
        FIN
    } state_t;

    state_t               state_q, state_d;
    logic [EXP_W-1:0]     shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 advance;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        mul_start = 1'b0;
        mul_sel   = SEL_SQ;
        done      = 1'b0;
        advance   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRE;
                    shift_d = exponent;
                    idx_d   = IDX_TOP;
                    cnt_d   = '0;
                end
            end
            PRE: begin
                mul_start = 1'b1;
                mul_sel   = SEL_PRE;
                cnt_d     = cnt_q + CNT_W'(1);
                state_d   = PRE_W;
            end
            PRE_W: begin
                if (mul_done) begin
                    idx_d = IDX_TOP;
`ifdef EXP_SEQ_SKIP_LZ_EN
                    state_d = SCAN;
`else
                    state_d = SQ;
`endif
                end
            end
            SCAN: begin
`ifdef EXP_SEQ_SKIP_LZ_EN
                if (shift_q[EXP_W-1]) begin
                    state_d = SQ;
                end else if (idx_q == '0) begin
                    state_d = POST;
                end else begin
                    shift_d = shift_q << 1;
                    idx_d   = idx_q - IDX_W'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            SQ: begin
                mul_start = 1'b1;
                mul_sel   = SEL_SQ;
                cnt_d     = cnt_q + CNT_W'(1);
                state_d   = SQ_W;
            end
            SQ_W: begin
                if (mul_done) begin
                    if (shift_q[EXP_W-1]) begin
                        state_d = MUL;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            MUL: begin
                mul_start = 1'b1;
                mul_sel   = SEL_MUL;
                cnt_d     = cnt_q + CNT_W'(1);
                state_d   = MUL_W;
            end
            MUL_W: begin
                if (mul_done) begin
                    advance = 1'b1;
                end
            end
            POST: begin
                mul_start = 1'b1;
                mul_sel   = SEL_POST;
                cnt_d     = cnt_q + CNT_W'(1);
                state_d   = POST_W;
            end
            POST_W: begin
                if (mul_done) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bit-advance: the shift register MSB always holds the bit at idx_q.
        if (advance) begin
            if (idx_q == '0) begin
                state_d = POST;
            end else begin
                shift_d = shift_q << 1;
                idx_d   = idx_q - IDX_W'(1);
                state_d = SQ;
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign op_count = cnt_q;

endmodule

// File: tb/tb_exp_sequencer.sv
// Randomized self-checking bench for exp_sequencer against an operation-list model.
module tb_exp_sequencer;

    localparam int EXP_W = 512;
    localparam int CNT_W = $clog2(2*EXP_W+3);
`ifdef EXP_SEQ_SKIP_LZ_EN
    localparam bit SKIP_LZ = 1'b1;
`else
    localparam bit SKIP_LZ = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic             mul_done = 1'b0;
    logic [EXP_W-1:0] exponent = '0;
    logic             mul_start;
    logic [1:0]       mul_sel;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] op_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];

    always #5 clk = ~clk;

    exp_sequencer #(.EXP_W(EXP_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .exponent  (exponent),
        .mul_start (mul_start),
        .mul_sel   (mul_sel),
        .mul_done  (mul_done),
        .busy      (busy),
        .done      (done),
        .op_count  (op_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int top_bit(input logic [EXP_W-1:0] e);
        for (int i = EXP_W-1; i >= 0; i--)
            if (e[i]) return i;
        return -1;
    endfunction

    // Operation list: convert in, square (+multiply on a 1) per bit from the top, convert out.
    task automatic build_model(input logic [EXP_W-1:0] e);
        int top;
        exp_q.delete();
        exp_q.push_back(2'b11);
        top = SKIP_LZ ? top_bit(e) : EXP_W-1;
        for (int i = top; i >= 0; i--) begin
            exp_q.push_back(2'b00);
            if (e[i]) exp_q.push_back(2'b01);
        end
        exp_q.push_back(2'b10);
    endtask

    task automatic run(input string name, input logic [EXP_W-1:0] e, input int lat, input bit inject);
        int cyc, pend, dones, extra, first_cyc, second_cyc, bad, sel_bad, busy_bad, gap_exp, top;
        bit fin, was_idle;
        build_model(e);
        got_q.delete();
        @(negedge clk);
        exponent = e;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        exponent = ~e;
        cyc = 0; pend = -1; dones = 0; extra = 0; fin = 1'b0;
        first_cyc = -1; second_cyc = -1; sel_bad = 0; busy_bad = 0;
        while (!fin && cyc < 20000) begin
            mul_done = 1'b0;
            start    = 1'b0;
            was_idle = (pend < 0);
            if (mul_start) begin
                got_q.push_back(mul_sel);
                if (got_q.size() == 1) first_cyc = cyc;
                else if (got_q.size() == 2) second_cyc = cyc;
                pend = lat;
            end else begin
                if (mul_sel != 2'b00) sel_bad++;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        mul_done = 1'b1;
                        pend = -1;
                    end
                end
            end
            if (!busy) busy_bad++;
            if (done) begin
                dones++;
                fin = 1'b1;
            end
            if (inject && was_idle && $urandom_range(0, 3) == 0) mul_done = 1'b1;
            if (inject && $urandom_range(0, 3) == 0) start = 1'b1;
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        mul_done = 1'b0;
        chk({name, "_finished"}, 64'(fin), 64'd1);
        chk({name, "_num_ops"}, got_q.size(), exp_q.size());
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                bad = i;
                break;
            end
        end
        chk({name, "_sel_first_diff_idx"}, bad, -1);
        chk({name, "_op_count"}, op_count, exp_q.size());
        chk({name, "_busy_after"}, busy, 0);
        chk({name, "_done_width"}, done, 0);
        chk({name, "_sel_when_idle"}, sel_bad, 0);
        chk({name, "_busy_during"}, busy_bad, 0);
        top = top_bit(e);
        gap_exp = lat + 1 + (SKIP_LZ ? ((top < 0) ? EXP_W : EXP_W - top) : 0);
        chk({name, "_first_gap"}, second_cyc - first_cyc, gap_exp);
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
            if (mul_start || busy) extra++;
        end
        chk({name, "_done_pulses"}, dones, 1);
        chk({name, "_quiet_after"}, extra, 0);
        chk({name, "_op_count_held"}, op_count, exp_q.size());
    endtask

    task automatic reset_mid();
        int cyc, pend, noise;
        bit hit;
        cyc = 0; pend = -1; hit = 1'b0; noise = 0;
        @(negedge clk);
        exponent = EXP_W'(5);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        while (!hit && cyc < 20000) begin
            mul_done = 1'b0;
            if (mul_start) begin
                if (mul_sel == 2'b01) hit = 1'b1;
                else pend = 3;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mul_done = 1'b1;
                    pend = -1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        mul_done = 1'b0;
        chk("rst_reached_mul", 64'(hit), 64'd1);
        chk("rst_busy_in_mul_w", busy, 1);
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        resetn   = 1'b1;
        mul_done = 1'b1;
        @(negedge clk);
        mul_done = 1'b0;
        repeat (5) begin
            if (mul_start || done || busy || op_count != 0 || mul_sel != 2'b00) noise++;
            @(negedge clk);
        end
        chk("rst_late_done_ignored", noise, 0);
    endtask

    initial begin
        logic [EXP_W-1:0] e;
        int lat;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_mul_start", mul_start, 0);
        chk("reset_mul_sel", mul_sel, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_op_count", op_count, 0);
        resetn = 1'b1;
        @(negedge clk);

        run("exp5", EXP_W'(5), 3, 1'b0);
        run("exp0", '0, 2, 1'b0);
        run("ones", '1, 1, 1'b0);
        run("inject5", EXP_W'(5), 2, 1'b1);

        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < EXP_W/32; w++) e[w*32 +: 32] = $urandom;
            e = e >> $urandom_range(0, EXP_W-1);
            lat = $urandom_range(1, 4);
            run($sformatf("rand%0d", k), e, lat, k[0]);
        end

        reset_mid();
        run("after_rst", EXP_W'(6) | (EXP_W'(1) << (EXP_W-1)), 2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
